// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word type, special instruction words and fetch FSM states
package cpu_pkg;
  typedef logic [15:0] word_t;
  typedef enum logic {RUN, HALT} fetch_state_t;
  localparam word_t HALT_WORD = 16'hEBCF;
  localparam word_t NOP_WORD = 16'h0000;
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter register and next-PC mux (freeze > branch > stall > increment)
// Ports: clk, rst (async, active-low), freeze (FSM halted), stall, branch_taken,
//   branch_target (word address), pc (current word address).
module fetch_pc
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  freeze,
  input  logic  stall,
  input  logic  branch_taken,
  input  word_t branch_target,
  output word_t pc
);
  word_t nxt;
  always_comb nxt = freeze ? pc : branch_taken ? branch_target : stall ? pc : pc + 16'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc <= RESET_PC;
    else pc <= nxt;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register, halt FSM and delivered-instruction counter
// Ports: clk, rst (async, active-low), stall, branch_taken, branch_target, instruction (zero-latency
//   imem read data) in; read_address, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count out.
// Build option: define FETCH_HALT_DETECT_EN to stop fetching after delivering HALT_WORD.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  branch_taken,
  input  word_t branch_target,
  input  word_t instruction,
  output word_t read_address,
  output word_t ifid_instr,
  output word_t ifid_pc,
  output logic  ifid_valid,
  output logic  halted,
  output word_t fetch_count
);
`ifdef FETCH_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif
  fetch_state_t state;
  logic halted_r;
  word_t pc;
  logic is_halt;
  always_comb is_halt = HALT_EN && instruction == HALT_WORD;
  assign read_address = pc;
  assign halted = HALT_EN & halted_r;
  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .freeze(state == HALT), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      halted_r <= 1'b0;
      ifid_instr <= NOP_WORD;
      ifid_pc <= 16'h0000;
      ifid_valid <= 1'b0;
      fetch_count <= 16'h0000;
    end else if (state == HALT) begin
      ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      // one-bubble flush; ifid_pc and count keep their last delivered values
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_instr <= instruction;
      ifid_pc <= pc;
      ifid_valid <= 1'b1;
      fetch_count <= fetch_count + 16'd1;
      if (is_halt) begin
        state <= HALT;
        halted_r <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] instruction, read_address, ifid_instr, ifid_pc, fetch_count;
  logic ifid_valid, halted;
  logic [15:0] mem [0:63];
  int checks = 0;
  int errors = 0;
`ifdef FETCH_HALT_DETECT_EN
  localparam logic HALT_EXP = 1'b1;
`else
  localparam logic HALT_EXP = 1'b0;
`endif

  always #5 clk = ~clk;
  assign instruction = mem[read_address[5:0]];

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instruction(instruction),
    .read_address(read_address), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
  );

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required summary");
    $fatal(1);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (read_address !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", read_address); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || ifid_pc !== 16'h0000) begin errors++; $display("FAIL reset_ifid: got v=%b i=%h p=%h want 0 0000 0000", ifid_valid, ifid_instr, ifid_pc); end
    checks++; if (fetch_count !== 16'h0000 || halted !== 1'b0) begin errors++; $display("FAIL reset_cnt: got c=%h h=%b want 0000 0", fetch_count, halted); end
    rst = 1'b1;
  endtask

  task automatic test_sequential;
    edges(3);
    checks++; if (ifid_pc !== 16'd2 || ifid_instr !== 16'h034C) begin errors++; $display("FAIL seq_ifid: got p=%h i=%h want 0002 034c", ifid_pc, ifid_instr); end
    checks++; if (ifid_valid !== 1'b1 || fetch_count !== 16'd3) begin errors++; $display("FAIL seq_cnt: got v=%b c=%0d want 1 3", ifid_valid, fetch_count); end
    checks++; if (read_address !== 16'd3) begin errors++; $display("FAIL seq_addr: got %0d want 3", read_address); end
  endtask

  task automatic test_stall;
    edges(1);
    stall = 1'b1;
    edges(2);
    checks++; if (read_address !== 16'd4) begin errors++; $display("FAIL stall_addr: got %0d want 4", read_address); end
    checks++; if (ifid_pc !== 16'd3 || ifid_instr !== 16'hA003 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid: got p=%h i=%h v=%b want 0003 a003 1", ifid_pc, ifid_instr, ifid_valid); end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d want 4", fetch_count); end
    stall = 1'b0;
    edges(1);
    checks++; if (ifid_pc !== 16'd4 || fetch_count !== 16'd5) begin errors++; $display("FAIL stall_release: got p=%0d c=%0d want 4 5", ifid_pc, fetch_count); end
  endtask

  task automatic test_branch;
    edges(7);
    checks++; if (read_address !== 16'd12) begin errors++; $display("FAIL br_pre: got %0d want 12", read_address); end
    branch_taken = 1'b1;
    branch_target = 16'h000D;
    edges(1);
    branch_taken = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || read_address !== 16'd13 || ifid_instr !== 16'h0000) begin errors++; $display("FAIL br_flush: got v=%b a=%0d i=%h want 0 13 0000", ifid_valid, read_address, ifid_instr); end
    checks++; if (ifid_pc !== 16'd11 || fetch_count !== 16'd12) begin errors++; $display("FAIL br_hold: got p=%0d c=%0d want 11 12", ifid_pc, fetch_count); end
    edges(1);
    checks++; if (ifid_pc !== 16'd13 || ifid_instr !== 16'h4705 || ifid_valid !== 1'b1) begin errors++; $display("FAIL br_target: got p=%0d i=%h v=%b want 13 4705 1", ifid_pc, ifid_instr, ifid_valid); end
  endtask

  task automatic test_branch_stall;
    branch_taken = 1'b1;
    stall = 1'b1;
    branch_target = 16'h0010;
    edges(1);
    branch_taken = 1'b0;
    stall = 1'b0;
    checks++; if (read_address !== 16'd16 || ifid_valid !== 1'b0) begin errors++; $display("FAIL br_stall: got a=%0d v=%b want 16 0", read_address, ifid_valid); end
    checks++; if (fetch_count !== 16'd13) begin errors++; $display("FAIL br_stall_cnt: got %0d want 13", fetch_count); end
  endtask

  task automatic test_halt;
    edges(9);
    checks++; if (read_address !== 16'd25 || fetch_count !== 16'd22) begin errors++; $display("FAIL halt_pre: got a=%0d c=%0d want 25 22", read_address, fetch_count); end
    edges(1);
    checks++; if (ifid_instr !== 16'hEBCF || ifid_valid !== 1'b1 || halted !== HALT_EXP) begin errors++; $display("FAIL halt_deliver: got i=%h v=%b h=%b want ebcf 1 %b", ifid_instr, ifid_valid, halted, HALT_EXP); end
    edges(1);
    if (HALT_EXP) begin
      checks++; if (ifid_valid !== 1'b0 || read_address !== 16'd26 || halted !== 1'b1) begin errors++; $display("FAIL halt_freeze: got v=%b a=%0d h=%b want 0 26 1", ifid_valid, read_address, halted); end
      branch_taken = 1'b1;
      stall = 1'b1;
      branch_target = 16'h0005;
      edges(2);
      branch_taken = 1'b0;
      stall = 1'b0;
      checks++; if (read_address !== 16'd26 || ifid_valid !== 1'b0 || fetch_count !== 16'd23) begin errors++; $display("FAIL halt_ignore: got a=%0d v=%b c=%0d want 26 0 23", read_address, ifid_valid, fetch_count); end
    end else begin
      checks++; if (read_address !== 16'd27 || halted !== 1'b0 || ifid_pc !== 16'd26) begin errors++; $display("FAIL nohalt_run: got a=%0d h=%b p=%0d want 27 0 26", read_address, halted, ifid_pc); end
      edges(1);
      checks++; if (ifid_valid !== 1'b1 || fetch_count !== 16'd25) begin errors++; $display("FAIL nohalt_cnt: got v=%b c=%0d want 1 25", ifid_valid, fetch_count); end
    end
  endtask

  task automatic test_async_reset;
    #2 rst = 1'b0;
    #1;
    checks++; if (read_address !== 16'h0000 || halted !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL async_rst: got a=%h h=%b v=%b want 0000 0 0", read_address, halted, ifid_valid); end
    checks++; if (ifid_instr !== 16'h0000 || ifid_pc !== 16'h0000 || fetch_count !== 16'h0000) begin errors++; $display("FAIL async_rst_regs: got i=%h p=%h c=%h want 0000 0000 0000", ifid_instr, ifid_pc, fetch_count); end
    @(negedge clk);
    rst = 1'b1;
    edges(1);
    checks++; if (ifid_pc !== 16'd0 || ifid_instr !== 16'hA000 || ifid_valid !== 1'b1 || fetch_count !== 16'd1) begin errors++; $display("FAIL post_rst: got p=%0d i=%h v=%b c=%0d want 0 a000 1 1", ifid_pc, ifid_instr, ifid_valid, fetch_count); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    mem[2] = 16'h034C;
    mem[13] = 16'h4705;
    mem[25] = 16'hEBCF;
    test_reset;
    test_sequential;
    test_stall;
    test_branch;
    test_branch_stall;
    test_halt;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
